// File: rtl/apb_ecc_stimulus_driver.sv
// APB master writing one ECC job (DATA_IN, CODEWORD_WIDTH, NOISE, CTRL) and returning the DUT result; APB_READBACK_EN adds register readback.
// Latency: accept at cycle 0, CTRL access at 8, earliest rsp_valid at 10 (16 with readback); timeout after TIMEOUT_CYCLES wait cycles.
// Backpressure: req_ready only in IDLE; no PREADY, every APB access completes in one cycle.
module apb_ecc_stimulus_driver #(
    parameter int          DATA_WIDTH      = 32,
    parameter int          AMBA_ADDR_WIDTH = 20,
    parameter int          AMBA_WORD       = 32,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int          TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_ctrl,
    input  logic [AMBA_WORD-1:0]       req_data,
    input  logic [1:0]                 req_width,
    input  logic [AMBA_WORD-1:0]       req_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic                       operation_done,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_num_errors,
    output logic                       rsp_timeout,
    output logic                       rsp_rb_err,
    output logic                       busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETUP     = 3'd1;
    localparam logic [2:0] ACCESS    = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;
    localparam logic [2:0] RB_SETUP  = 3'd5;
    localparam logic [2:0] RB_ACCESS = 3'd6;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [AMBA_ADDR_WIDTH-1:0] BASE        = AMBA_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL   = BASE;
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA   = BASE + AMBA_ADDR_WIDTH'(4);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_WIDTH  = BASE + AMBA_ADDR_WIDTH'(8);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE  = BASE + AMBA_ADDR_WIDTH'(12);

    logic [2:0]           state;
    logic [1:0]           idx;
    logic [1:0]           lat_ctrl;
    logic [AMBA_WORD-1:0] lat_data;
    logic [1:0]           lat_width;
    logic [AMBA_WORD-1:0] lat_noise;
    logic [CNT_W-1:0]     wait_cnt;

    logic [AMBA_WORD-1:0]       idx_val;
    logic [AMBA_ADDR_WIDTH-1:0] idx_addr;

    // The write index selects both the register and its value; readback reuses it for indices 0..2.
    always_comb begin
        idx_val  = AMBA_WORD'(lat_ctrl);
        idx_addr = ADDR_CTRL;
        case (idx)
            2'd0: begin
                idx_val  = lat_data;
                idx_addr = ADDR_DATA;
            end
            2'd1: begin
                idx_val  = AMBA_WORD'(lat_width);
                idx_addr = ADDR_WIDTH;
            end
            2'd2: begin
                idx_val  = lat_noise;
                idx_addr = ADDR_NOISE;
            end
            default: begin
                idx_val  = AMBA_WORD'(lat_ctrl);
                idx_addr = ADDR_CTRL;
            end
        endcase
    end

    always_comb begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        case (state)
            SETUP, ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (state == ACCESS);
                PWRITE  = 1'b1;
                PADDR   = idx_addr;
                PWDATA  = idx_val;
            end
            RB_SETUP, RB_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (state == RB_ACCESS);
                PADDR   = idx_addr;
            end
            default: ;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

`ifdef APB_READBACK_EN
    logic rb_err;
    logic rsp_rb_err_q;
    assign rsp_rb_err = rsp_rb_err_q;
`else
    logic unused_prdata;
    assign unused_prdata = ^PRDATA;
    assign rsp_rb_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            lat_ctrl       <= '0;
            lat_data       <= '0;
            lat_width      <= '0;
            lat_noise      <= '0;
            wait_cnt       <= '0;
            rsp_data       <= '0;
            rsp_num_errors <= '0;
            rsp_timeout    <= 1'b0;
`ifdef APB_READBACK_EN
            rb_err         <= 1'b0;
            rsp_rb_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_ctrl  <= req_ctrl;
                        lat_data  <= req_data;
                        lat_width <= req_width;
                        lat_noise <= req_noise;
                        idx       <= '0;
`ifdef APB_READBACK_EN
                        rb_err    <= 1'b0;
`endif
                        state     <= SETUP;
                    end
                end
                SETUP: state <= ACCESS;
                ACCESS: begin
                    if (idx == 2'd3) begin
                        wait_cnt <= CNT_W'(1);
                        state    <= WAIT_DONE;
`ifdef APB_READBACK_EN
                    end else if (idx == 2'd2) begin
                        idx   <= '0;
                        state <= RB_SETUP;
`endif
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= SETUP;
                    end
                end
`ifdef APB_READBACK_EN
                RB_SETUP: state <= RB_ACCESS;
                RB_ACCESS: begin
                    if (PRDATA != idx_val) begin
                        rb_err <= 1'b1;
                    end
                    if (idx == 2'd2) begin
                        idx   <= 2'd3;
                        state <= SETUP;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= RB_SETUP;
                    end
                end
`endif
                WAIT_DONE: begin
                    // Completion takes priority over a timeout landing on the same cycle.
                    if (operation_done) begin
                        rsp_data       <= data_out;
                        rsp_num_errors <= num_of_errors;
                        rsp_timeout    <= 1'b0;
`ifdef APB_READBACK_EN
                        rsp_rb_err_q   <= rb_err;
`endif
                        state          <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_data       <= '0;
                        rsp_num_errors <= '0;
                        rsp_timeout    <= 1'b1;
`ifdef APB_READBACK_EN
                        rsp_rb_err_q   <= rb_err;
`endif
                        state          <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_ecc_stimulus_driver.sv
// Bench for apb_ecc_stimulus_driver: table vectors, mid-job reset sequence and random jobs vs a transfer-list model.
module tb_apb_ecc_stimulus_driver;

    localparam int T = 16;
`ifdef APB_READBACK_EN
    localparam bit RB_ON = 1'b1;
`else
    localparam bit RB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_ctrl = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_width = '0;
    logic [31:0] req_noise = '0;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PRDATA = '0;
    logic [31:0] data_out = '0;
    logic        operation_done = 1'b0;
    logic [1:0]  num_of_errors = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_num_errors;
    logic        rsp_timeout, rsp_rb_err, busy;

    always #5 clk = ~clk;

    apb_ecc_stimulus_driver #(
        .DATA_WIDTH(32), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .BASE_ADDR(0), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl), .req_data(req_data),
        .req_width(req_width), .req_noise(req_noise),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PRDATA(PRDATA),
        .data_out(data_out), .operation_done(operation_done), .num_of_errors(num_of_errors),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_num_errors(rsp_num_errors),
        .rsp_timeout(rsp_timeout), .rsp_rb_err(rsp_rb_err), .busy(busy)
    );

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] data;
        logic [1:0]  width;
        logic [31:0] noise;
        int          ds;       // done window, offsets from the first wait cycle
        int          de;
        logic [31:0] dv;
        logic [1:0]  ne;
        logic [31:0] corrupt;  // XOR applied to PRDATA on NOISE reads
    } job_t;

    typedef struct {
        job_t        j;
        int          exp_off;
        bit          exp_to;
        logic [31:0] exp_data;
        logic [1:0]  exp_ne;
        bit          exp_rb;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] regs [4];
    logic [31:0] prev_data = '0;
    logic [1:0]  prev_ne = '0;
    bit          prev_to = 1'b0;
    bit          prev_rb = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        if (!ok) chk("ready_wait", 64'd0, 64'd1);
    endtask

    task automatic run_job(input job_t j, output int obs_off, output bit obs_to,
                           output logic [31:0] obs_data, output logic [1:0] obs_ne, output bit obs_rb);
        logic [19:0] ta [8];
        logic [31:0] td [8];
        bit          tw [8];
        int n, L, W, rsp, i;
        bit e_to, e_rb, e_psel, dn, ok;
        logic [31:0] e_data;
        logic [1:0]  e_ne;
        obs_off = -1; obs_to = 0; obs_data = '0; obs_ne = '0; obs_rb = 0;
        n = 0;
        ta[n] = 20'h4; td[n] = j.data;           tw[n] = 1; n++;
        ta[n] = 20'h8; td[n] = {30'd0, j.width}; tw[n] = 1; n++;
        ta[n] = 20'hC; td[n] = j.noise;          tw[n] = 1; n++;
        if (RB_ON) begin
            ta[n] = 20'h4; td[n] = '0; tw[n] = 0; n++;
            ta[n] = 20'h8; td[n] = '0; tw[n] = 0; n++;
            ta[n] = 20'hC; td[n] = '0; tw[n] = 0; n++;
        end
        ta[n] = 20'h0; td[n] = {30'd0, j.ctrl};  tw[n] = 1; n++;
        L = 2 * n;
        W = L + 1;
        rsp  = W + T;
        e_to = 1;
        for (int c = W; c < W + T; c++) begin
            if (c - W >= j.ds && c - W <= j.de) begin
                rsp  = c + 1;
                e_to = 0;
                break;
            end
        end
        e_data = e_to ? 32'd0 : j.dv;
        e_ne   = e_to ? 2'd0 : j.ne;
        e_rb   = RB_ON && (j.corrupt != 0);

        wait_ready(ok);
        if (!ok) return;
        req_valid = 1; req_ctrl = j.ctrl; req_data = j.data; req_width = j.width; req_noise = j.noise;
        operation_done = 0;
        for (int k = 1; k <= rsp + 1; k++) begin
            @(negedge clk);
            e_psel = (k <= L);
            i = e_psel ? (k - 1) / 2 : 0;
            chk("psel", PSEL, e_psel);
            chk("penable", PENABLE, e_psel && (k % 2 == 0));
            chk("pwrite", PWRITE, e_psel ? tw[i] : 1'b0);
            chk("paddr", PADDR, e_psel ? ta[i] : 20'd0);
            chk("pwdata", PWDATA, e_psel ? td[i] : 32'd0);
            chk("rsp_valid", rsp_valid, k == rsp);
            chk("busy", busy, k <= rsp);
            chk("req_ready", req_ready, k > rsp);
            chk("rsp_data", rsp_data, (k >= rsp) ? e_data : prev_data);
            chk("rsp_num_errors", rsp_num_errors, (k >= rsp) ? e_ne : prev_ne);
            chk("rsp_timeout", rsp_timeout, (k >= rsp) ? e_to : prev_to);
            chk("rsp_rb_err", rsp_rb_err, (k >= rsp) ? e_rb : prev_rb);
            if (rsp_valid && obs_off < 0) begin
                obs_off = k - W; obs_to = rsp_timeout; obs_data = rsp_data;
                obs_ne = rsp_num_errors; obs_rb = rsp_rb_err;
            end
            // Environment: DUT register file and completion/junk drive for this cycle.
            if (PSEL && PENABLE && PWRITE) regs[PADDR[3:2]] = PWDATA;
            PRDATA = regs[PADDR[3:2]] ^ ((PADDR[3:0] == 4'hC) ? j.corrupt : 32'd0);
            dn = (k - W >= j.ds) && (k - W <= j.de);
            operation_done = dn;
            data_out       = dn ? j.dv : $urandom;
            num_of_errors  = dn ? j.ne : 2'($urandom);
            req_valid      = (k <= rsp) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_data = $urandom; req_noise = $urandom;
            req_ctrl = 2'($urandom); req_width = 2'($urandom);
        end
        operation_done = 0;
        req_valid = 0;
        prev_data = e_data; prev_ne = e_ne; prev_to = e_to; prev_rb = e_rb;
    endtask

    task automatic mid_reset();
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        req_valid = 1; req_data = 32'h11; req_width = 2'd1; req_noise = 32'h2; req_ctrl = 2'd2;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid = 0;
            if (k == 5) begin
                chk("psel_before_rst", PSEL, 1'b1);
                rst = 1;
            end
        end
        @(negedge clk);
        rst = 0;
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_pwrite", PWRITE, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        prev_data = '0; prev_ne = '0; prev_to = 0; prev_rb = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("dropped_rsp_valid", rsp_valid, 1'b0);
            chk("dropped_busy", busy, 1'b0);
            operation_done = 1'($urandom_range(0, 1));
        end
        operation_done = 0;
    endtask

    vec_t vt [9];

    initial begin
        int off;
        bit to, rb;
        logic [31:0] d;
        logic [1:0]  ne;
        job_t rj;

        for (int r = 0; r < 4; r++) regs[r] = '0;
        vt[0] = '{'{2'd0, 32'h0000_00A5, 2'd0, 32'h0, 2, 2, 32'h1234, 2'd1, 32'h0}, 3, 0, 32'h1234, 2'd1, 0};
        vt[1] = '{'{2'd1, 32'h5555_AAAA, 2'd1, 32'h10, -100, -100, 32'h9, 2'd1, 32'h0}, 16, 1, 32'h0, 2'd0, 0};
        vt[2] = '{'{2'd2, 32'h0F0F_0F0F, 2'd3, 32'h7, -1, -1, 32'hABCD, 2'd2, 32'h0}, 16, 1, 32'h0, 2'd0, 0};
        vt[3] = '{'{2'd1, 32'hDEAD_BEEF, 2'd2, 32'h3, 0, 0, 32'hCAFE_F00D, 2'd2, 32'h0}, 1, 0, 32'hCAFE_F00D, 2'd2, 0};
        vt[4] = '{'{2'd2, 32'h1, 2'd1, 32'h1, 15, 15, 32'h0BAD_F00D, 2'd3, 32'h0}, 16, 0, 32'h0BAD_F00D, 2'd3, 0};
        vt[5] = '{'{2'd0, 32'h2, 2'd0, 32'h0, 16, 16, 32'h5A5A, 2'd1, 32'h0}, 16, 1, 32'h0, 2'd0, 0};
        vt[6] = '{'{2'd1, 32'h3, 2'd2, 32'h8, -6, -1, 32'h7777, 2'd1, 32'h0}, 16, 1, 32'h0, 2'd0, 0};
        vt[7] = '{'{2'd2, 32'h4, 2'd3, 32'hFFFF_FFFF, -3, 1, 32'h1357_9BDF, 2'd2, 32'h0}, 1, 0, 32'h1357_9BDF, 2'd2, 0};
        vt[8] = '{'{2'd0, 32'h5, 2'd0, 32'h0, 2, 2, 32'h77, 2'd0, 32'hFFFF}, 3, 0, 32'h77, 2'd0, RB_ON};

        repeat (3) @(negedge clk);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_psel", PSEL, 1'b0);
        chk("reset_penable", PENABLE, 1'b0);
        chk("reset_pwrite", PWRITE, 1'b0);
        chk("reset_paddr", PADDR, 20'd0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_timeout", rsp_timeout, 1'b0);
        chk("reset_rsp_rb_err", rsp_rb_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 0;

        for (int v = 0; v < 9; v++) begin
            run_job(vt[v].j, off, to, d, ne, rb);
            chk($sformatf("tbl%0d_rsp_offset", v), 64'(off), 64'(vt[v].exp_off));
            chk($sformatf("tbl%0d_timeout", v), to, vt[v].exp_to);
            chk($sformatf("tbl%0d_data", v), d, vt[v].exp_data);
            chk($sformatf("tbl%0d_num_errors", v), ne, vt[v].exp_ne);
            chk($sformatf("tbl%0d_rb_err", v), rb, vt[v].exp_rb);
        end

        mid_reset();
        run_job(vt[0].j, off, to, d, ne, rb);
        chk("after_rst_rsp_offset", 64'(off), 64'(vt[0].exp_off));

        for (int r = 0; r < 40; r++) begin
            rj.ctrl  = 2'($urandom_range(0, 2));
            rj.data  = $urandom;
            rj.width = 2'($urandom);
            rj.noise = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                rj.ds = -100; rj.de = -100;
            end else begin
                rj.ds = int'($urandom_range(0, 24)) - 6;
                rj.de = rj.ds + int'($urandom_range(0, 3));
            end
            rj.dv      = $urandom;
            rj.ne      = 2'($urandom);
            rj.corrupt = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
            run_job(rj, off, to, d, ne, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_ecc_stimulus_driver.md
Name: apb_ecc_stimulus_driver

Overview:
- APB master that drives the ECC encoder/decoder DUT, directly upstream of it on the shared APB/ECC interface.
- Accepts one ECC job per request handshake and writes the job to the DUT's registers: DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL.
- Waits for operation_done, captures data_out and num_of_errors, and returns them on a response pulse.
- The same bus activity is what the DUT assertions and the golden model observe.

Parameters:
- DATA_WIDTH, 32, width of DUT data_out / rsp_data.
- AMBA_ADDR_WIDTH, 20, PADDR width.
- AMBA_WORD, 32, PWDATA/PRDATA width.
- BASE_ADDR, 0, DUT register base; offsets are CTRL 0x0, DATA_IN 0x4, CODEWORD_WIDTH 0x8, NOISE 0xC.
- TIMEOUT_CYCLES, 16, maximum WAIT_DONE cycles before a timeout response (≥2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  job request
- req_ready  out  1  driver can accept a job
- req_ctrl  in  2  CTRL value (0 encode, 1 decode, 2 full channel)
- req_data  in  AMBA_WORD  DATA_IN value
- req_width  in  2  CODEWORD_WIDTH value
- req_noise  in  AMBA_WORD  NOISE value
- PADDR  out  AMBA_ADDR_WIDTH  APB address
- PWDATA  out  AMBA_WORD  APB write data
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PRDATA  in  AMBA_WORD  APB read data (used only with the optional feature)
- data_out  in  DATA_WIDTH  DUT result
- operation_done  in  1  DUT completion
- num_of_errors  in  2  DUT error count
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  DATA_WIDTH  captured data_out
- rsp_num_errors  out  2  captured num_of_errors
- rsp_timeout  out  1  job timed out
- rsp_rb_err  out  1  readback mismatch (0 when the optional feature is out)
- busy  out  1  state ≠ IDLE

Behaviour:
- States: IDLE, SETUP, ACCESS, WAIT_DONE, RESP; plus RB_SETUP and RB_ACCESS with the optional feature.
- Reset values: all outputs 0 except req_ready=1. After rst, state is IDLE and the write index is 0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields, set write index to 0, go to SETUP.
- Write order is fixed: index 0 DATA_IN, 1 CODEWORD_WIDTH, 2 NOISE, 3 CTRL.
- SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR=BASE_ADDR+offset(index), PWDATA=latched value. req_ctrl and req_width are zero-extended.
- ACCESS:
  - PSEL=1, PENABLE=1, PADDR/PWDATA/PWRITE held from SETUP. No PREADY; every access is exactly one cycle.
  - index<3: increment index, go to SETUP; PSEL stays 1 back-to-back.
  - index=3: go to WAIT_DONE.
- WAIT_DONE:
  - PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0. Cycle counter starts at 1.
  - operation_done=1: capture data_out and num_of_errors the same cycle, rsp_timeout=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES: rsp_data=0, rsp_num_errors=0, rsp_timeout=1, go to RESP.
  - operation_done and the timeout in the same cycle: done wins.
  - operation_done asserted during SETUP/ACCESS is ignored as stale.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_* hold their values until the next RESP.
- Latency: request accepted at cycle 0; CTRL ACCESS at cycle 8; earliest rsp_valid at cycle 10 (done seen at cycle 9).
- req_valid while busy is not accepted; req_ready=0.
- rst asserted mid-job:
  - Next edge returns to IDLE with PSEL/PENABLE/PWRITE=0.
  - The job is dropped with no rsp_valid.
  - rsp_* are cleared.

Optional Feature:
- Macro: APB_READBACK_EN.
- Defined:
  - After the NOISE write (index 2), issue three APB reads (RB_SETUP/RB_ACCESS, PWRITE=0, PWDATA=0) of DATA_IN, CODEWORD_WIDTH and NOISE.
  - Sample PRDATA in RB_ACCESS and compare it with the latched value; rsp_rb_err = OR of mismatches.
  - Then proceed to the CTRL write.
  - Adds 6 cycles: earliest rsp_valid at cycle 16.
- Undefined: no read transfers occur and rsp_rb_err is tied to 0.

Test Plan:
1. After rst: req_ready=1, PSEL=0. req_data=0x0000_00A5, req_width=0, req_noise=0, req_ctrl=0 -> PADDR sequence 0x4,0x8,0xC,0x0 on cycles 2,4,6,8 with PENABLE=1 and PWDATA 0xA5,0,0,0.
2. Done response: DUT raises operation_done at cycle 11 with data_out=0x1234, num_of_errors=1 -> rsp_valid at cycle 12 only, rsp_data=0x1234, rsp_num_errors=1, rsp_timeout=0.
3. Timeout: operation_done never rises, TIMEOUT_CYCLES=16 -> rsp_valid with rsp_timeout=1 and rsp_data=0 at cycle 25.
4. Stale done: operation_done=1 during the CTRL ACCESS cycle only -> ignored; the job times out.
5. rst at cycle 5 mid-job -> PSEL=0 at cycle 6, no rsp_valid, req_ready=1. A new request then completes normally.
6. With APB_READBACK_EN, model returns PRDATA=0xFFFF on the NOISE read while 0 was written -> rsp_rb_err=1 and the CTRL write still occurs at cycle 14.
